// File: rtl/block_mem_arbiter_pkg.sv
// Shared defaults and FSM state type for the block-memory arbiter.
package block_mem_arbiter_pkg;
  localparam int ADDR_W_DEF     = 12;
  localparam int DEPTH_DEF      = 3072;
  localparam int DATA_W_DEF     = 8;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } arb_state_t;
endpackage

// File: rtl/block_mem_arbiter_write_fifo.sv
// Host write FIFO: power-of-two depth, registered not-full flag as ready.
module arb_write_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             ready
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count, count_next;
  logic             do_push, do_pop;

  assign empty      = (count == '0);
  assign do_pop     = pop && !empty;
  assign do_push    = push && ((count != CNT_FULL) || do_pop);
  assign count_next = count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
  assign pop_data   = store[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
      ready <= (count_next != CNT_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/block_mem_arbiter.sv
// Single-port block RAM arbiter: display reads > clear fill > host FIFO writes.
// Optional macro ARB_STARVE_GUARD_EN forces a FIFO write after 16 blocked cycles.
//   state | meaning
//   IDLE  | display reads and FIFO drain share the RAM
//   CLEAR | fill every entry with the latched colour, FIFO held
module block_mem_arbiter
  import block_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  input  logic              clear_start,
  input  logic [DATA_W-1:0] clear_color,
  output logic              clear_busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int FW = ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  arb_state_t        state;
  logic [ADDR_W-1:0] clr_addr, addr_hold, head_addr;
  logic [DATA_W-1:0] clr_color, wdata_hold, head_data;
  logic [FW-1:0]     fifo_head;
  logic              fifo_empty, fifo_push, force_fifo;
  logic              disp_grant, clear_grant, fifo_grant;
  logic              rd_pend, rd_dummy;

  // Out-of-range host writes are handshaken but never enter the FIFO.
  assign fifo_push = host_valid && host_ready &&
                     ({1'b0, host_addr} < (ADDR_W+1)'(DEPTH));
  assign {head_addr, head_data} = fifo_head;

  arb_write_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({host_addr, host_data}),
    .pop       (fifo_grant),
    .pop_data  (fifo_head),
    .empty     (fifo_empty),
    .ready     (host_ready)
  );

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [4:0] GUARD_LIMIT = 5'd16;
  logic [4:0] starve_cnt;
  logic       blocked;

  assign force_fifo = (starve_cnt == GUARD_LIMIT);
  assign blocked    = (state == IDLE) && !fifo_empty && disp_req && !force_fifo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       starve_cnt <= '0;
    else if (force_fifo || !blocked) starve_cnt <= '0;
    else                           starve_cnt <= starve_cnt + 5'd1;
  end
`else
  assign force_fifo = 1'b0;
`endif

  assign fifo_grant  = !rst && (state == IDLE) && !fifo_empty && (!disp_req || force_fifo);
  assign disp_grant  = !rst && disp_req && !fifo_grant;
  assign clear_grant = !rst && (state == CLEAR) && !disp_req;

  // RAM controls are combinational so a read lands in the request cycle.
  always_comb begin
    mem_en    = disp_grant | clear_grant | fifo_grant;
    mem_we    = clear_grant | fifo_grant;
    mem_addr  = addr_hold;
    mem_wdata = wdata_hold;
    if (disp_grant) begin
      mem_addr = disp_addr;
    end else if (clear_grant) begin
      mem_addr  = clr_addr;
      mem_wdata = clr_color;
    end else if (fifo_grant) begin
      mem_addr  = head_addr;
      mem_wdata = head_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      clear_busy <= 1'b0;
      clr_addr   <= '0;
      clr_color  <= '0;
      addr_hold  <= '0;
      wdata_hold <= '0;
      rd_pend    <= 1'b0;
      rd_dummy   <= 1'b0;
      disp_valid <= 1'b0;
      disp_data  <= '0;
    end else begin
      addr_hold  <= mem_addr;
      wdata_hold <= mem_wdata;
      rd_pend    <= disp_req;
      rd_dummy   <= disp_req && fifo_grant;
      disp_valid <= rd_pend;
      // A read displaced by the guard repeats the previous pixel.
      if (rd_pend && !rd_dummy) disp_data <= mem_rdata;
      if (state == IDLE) begin
        if (clear_start) begin
          state      <= CLEAR;
          clear_busy <= 1'b1;
          clr_addr   <= '0;
          clr_color  <= clear_color;
        end
      end else if (clear_grant) begin
        if (clr_addr == LAST_ADDR) begin
          state      <= IDLE;
          clear_busy <= 1'b0;
        end else begin
          clr_addr <= clr_addr + ADDR_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_block_mem_arbiter.sv
// Self-checking bench for block_mem_arbiter: directed scenarios plus a randomized run.
module tb_block_mem_arbiter;
  localparam int DEPTH = 3072;

  typedef struct { logic [11:0] addr; logic [7:0] data; } wr_t;
  typedef struct { int due; logic [7:0] data; bit dummy; } rd_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        disp_req, disp_valid, host_valid, host_ready, clear_start, clear_busy;
  logic        mem_en, mem_we;
  logic [11:0] disp_addr, host_addr, mem_addr;
  logic [7:0]  disp_data, host_data, clear_color, mem_wdata, mem_rdata;
  logic [7:0]  ram [DEPTH];
  int          n_checks = 0;
  int          n_pass = 0;

  block_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_valid(disp_valid), .disp_data(disp_data),
    .host_valid(host_valid), .host_ready(host_ready), .host_addr(host_addr), .host_data(host_data),
    .clear_start(clear_start), .clear_color(clear_color), .clear_busy(clear_busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: synchronous single port, read data one cycle after mem_en.
  always @(posedge clk) begin
    if (mem_en && mem_addr < 12'(DEPTH)) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; disp_req = 0; disp_addr = 0; host_valid = 0; host_addr = 0; host_data = 0;
    clear_start = 0; clear_color = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (disp_valid !== 1'b0) $display("FAIL rst_disp_valid got %0b want 0", disp_valid); else n_pass++;
    n_checks++; if (disp_data !== 8'h00) $display("FAIL rst_disp_data got %0h want 0", disp_data); else n_pass++;
    n_checks++; if (host_ready !== 1'b0) $display("FAIL rst_host_ready got %0b want 0", host_ready); else n_pass++;
    n_checks++; if (clear_busy !== 1'b0) $display("FAIL rst_clear_busy got %0b want 0", clear_busy); else n_pass++;
    n_checks++; if ({mem_en, mem_we} !== 2'b00) $display("FAIL rst_mem_en_we got %0b want 00", {mem_en, mem_we}); else n_pass++;
    n_checks++; if ({mem_addr, mem_wdata} !== 20'h0) $display("FAIL rst_mem_addr_wdata got %0h want 0", {mem_addr, mem_wdata}); else n_pass++;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_checks++; if (host_ready !== 1'b0) $display("FAIL ready_before_edge got %0b want 0", host_ready); else n_pass++;
    tick();
    @(negedge clk);
    n_checks++; if (host_ready !== 1'b1) $display("FAIL ready_after_release got %0b want 1", host_ready); else n_pass++;
    tick();
  endtask

  task automatic test_read();
    host_valid = 1; host_addr = 12'h123; host_data = 8'h5A;
    tick();
    host_valid = 0;
    repeat (3) tick();
    disp_req = 1; disp_addr = 12'h123;
    @(negedge clk);
    n_checks++;
    if ({mem_en, mem_we, mem_addr} !== {2'b10, 12'h123})
      $display("FAIL read_issue got en=%0b we=%0b addr=%0h want 1 0 123", mem_en, mem_we, mem_addr);
    else n_pass++;
    tick();
    disp_req = 0;
    @(negedge clk);
    n_checks++; if (disp_valid !== 1'b0) $display("FAIL read_lat1 got valid=%0b want 0", disp_valid); else n_pass++;
    tick();
    @(negedge clk);
    n_checks++;
    if ({disp_valid, disp_data} !== {1'b1, 8'h5A})
      $display("FAIL read_lat2 got valid=%0b data=%0h want 1 5a", disp_valid, disp_data);
    else n_pass++;
    tick();
    @(negedge clk);
    n_checks++; if (disp_valid !== 1'b0) $display("FAIL read_pulse got valid=%0b want 0", disp_valid); else n_pass++;
    tick();
  endtask

  task automatic test_collision();
    host_valid = 1; host_addr = 12'h010; host_data = 8'h77;
    @(negedge clk);
    n_checks++;
    if ({mem_en, mem_addr} !== {1'b0, 12'h123})
      $display("FAIL idle_hold got en=%0b addr=%0h want 0 123", mem_en, mem_addr);
    else n_pass++;
    tick();
    host_valid = 0; disp_req = 1; disp_addr = 12'h020;
    @(negedge clk);
    n_checks++;
    if ({mem_en, mem_we, mem_addr} !== {2'b10, 12'h020})
      $display("FAIL coll_read_first got en=%0b we=%0b addr=%0h want 1 0 20", mem_en, mem_we, mem_addr);
    else n_pass++;
    tick();
    disp_req = 0;
    @(negedge clk);
    n_checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 12'h010, 8'h77})
      $display("FAIL coll_write_next got en=%0b we=%0b addr=%0h data=%0h want 1 1 10 77",
               mem_en, mem_we, mem_addr, mem_wdata);
    else n_pass++;
    repeat (3) tick();
  endtask

  task automatic test_clear();
    int exp_addr = 0;
    clear_start = 1; clear_color = 8'h00;
    @(negedge clk);
    n_checks++; if (clear_busy !== 1'b0) $display("FAIL clear_busy_early got %0b want 0", clear_busy); else n_pass++;
    tick();
    clear_start = 0;
    for (int c = 0; c < 3100; c++) begin
      @(negedge clk);
      if (!clear_busy) break;
      n_checks++;
      if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 12'(exp_addr), 8'h00})
        $display("FAIL clear_write got en=%0b we=%0b addr=%0d data=%0h want 1 1 %0d 0",
                 mem_en, mem_we, mem_addr, mem_wdata, exp_addr);
      else n_pass++;
      exp_addr++;
      tick();
    end
    n_checks++; if (exp_addr !== DEPTH) $display("FAIL clear_count got %0d want %0d", exp_addr, DEPTH); else n_pass++;
    n_checks++; if (clear_busy !== 1'b0) $display("FAIL clear_end_busy got %0b want 0", clear_busy); else n_pass++;
    tick();
  endtask

  task automatic test_backpressure();
    logic [11:0] hw_a [5];
    logic [7:0]  hw_d [5];
    int nw = 0;
    int acc = 0;
    hw_a = '{12'h200, 12'h300, 12'h010, 12'h200, 12'h555};
    hw_d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int c = 0; c < 3300 && nw < DEPTH + 4; c++) begin
      clear_start = (c == 0 || c == 2);
      clear_color = (c == 0) ? 8'h3C : 8'hA5;
      host_valid  = (c < 5);
      host_addr   = hw_a[c < 5 ? c : 4];
      host_data   = hw_d[c < 5 ? c : 4];
      @(negedge clk);
      if (c == 4) begin
        n_checks++; if (host_ready !== 1'b0) $display("FAIL bp_ready_low got %0b want 0", host_ready); else n_pass++;
      end
      if (host_valid && host_ready) acc++;
      if (mem_en && mem_we) begin
        n_checks++;
        if (nw < DEPTH) begin
          if ({clear_busy, mem_addr, mem_wdata} !== {1'b1, 12'(nw), 8'h3C})
            $display("FAIL bp_clear_write got busy=%0b addr=%0d data=%0h want 1 %0d 3c",
                     clear_busy, mem_addr, mem_wdata, nw);
          else n_pass++;
        end else begin
          if ({mem_addr, mem_wdata} !== {hw_a[nw-DEPTH], hw_d[nw-DEPTH]})
            $display("FAIL bp_fifo_order got addr=%0h data=%0h want %0h %0h",
                     mem_addr, mem_wdata, hw_a[nw-DEPTH], hw_d[nw-DEPTH]);
          else n_pass++;
        end
        nw++;
      end
      tick();
    end
    clear_start = 0; host_valid = 0;
    n_checks++; if (acc !== 4) $display("FAIL bp_accepted got %0d want 4", acc); else n_pass++;
    n_checks++; if (nw !== DEPTH + 4) $display("FAIL bp_writes got %0d want %0d", nw, DEPTH + 4); else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({mem_en, host_ready, clear_busy} !== 3'b010)
      $display("FAIL bp_settle got en=%0b ready=%0b busy=%0b want 0 1 0", mem_en, host_ready, clear_busy);
    else n_pass++;
    tick();
  endtask

`ifdef ARB_STARVE_GUARD_EN
  task automatic test_guard();
    logic [7:0] exp_rd [20];
    host_valid = 1; host_addr = 12'h040; host_data = 8'h99;
    tick();
    host_valid = 0;
    for (int i = 0; i < 20; i++) begin
      disp_req = 1;
      disp_addr = (i == 15) ? 12'h300 : 12'h100 + 12'(i);
      @(negedge clk);
      exp_rd[i] = ram[disp_addr];
      n_checks++;
      if (i == 16) begin
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 12'h040, 8'h99})
          $display("FAIL guard_grant got en=%0b we=%0b addr=%0h data=%0h want 1 1 40 99",
                   mem_en, mem_we, mem_addr, mem_wdata);
        else n_pass++;
      end else begin
        if ({mem_en, mem_we, mem_addr} !== {2'b10, disp_addr})
          $display("FAIL guard_read i=%0d got en=%0b we=%0b addr=%0h", i, mem_en, mem_we, mem_addr);
        else n_pass++;
      end
      if (i == 18) begin
        n_checks++;
        if ({disp_valid, disp_data} !== {1'b1, exp_rd[15]})
          $display("FAIL guard_repeat got valid=%0b data=%0h want 1 %0h", disp_valid, disp_data, exp_rd[15]);
        else n_pass++;
      end
      tick();
    end
    disp_req = 0;
    repeat (3) tick();
  endtask
`endif

  task automatic test_random();
    wr_t q[$];
    rd_t rq[$];
    int blk = 0;
    logic [7:0] last_del = 8'h00;
    for (int c = 0; c < 640; c++) begin
      bit fw, exp_ready, busy_start;
      logic [7:0] exp;
      bit traffic = (c < 600);
      disp_req   = traffic && ($urandom_range(0, 1) == 1);
      disp_addr  = 12'($urandom_range(0, DEPTH - 1));
      host_valid = traffic && ($urandom_range(0, 9) < 4);
      host_addr  = ($urandom_range(0, 7) == 0) ? 12'($urandom_range(DEPTH, 4095))
                                               : 12'($urandom_range(0, DEPTH - 1));
      host_data  = 8'($urandom);
      @(negedge clk);
      fw = 0;
`ifdef ARB_STARVE_GUARD_EN
      fw = (blk == 16);
`endif
      exp_ready  = (q.size() < 4);
      busy_start = (q.size() > 0);
      n_checks++;
      if (host_ready !== exp_ready) $display("FAIL rnd_ready c=%0d got %0b want %0b", c, host_ready, exp_ready);
      else n_pass++;
      n_checks++;
      if (disp_req && !fw) begin
        if ({mem_en, mem_we, mem_addr} !== {2'b10, disp_addr})
          $display("FAIL rnd_read c=%0d got en=%0b we=%0b addr=%0h want 1 0 %0h", c, mem_en, mem_we, mem_addr, disp_addr);
        else n_pass++;
      end else if (q.size() > 0) begin
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, q[0].addr, q[0].data})
          $display("FAIL rnd_write c=%0d got en=%0b we=%0b addr=%0h data=%0h want 1 1 %0h %0h",
                   c, mem_en, mem_we, mem_addr, mem_wdata, q[0].addr, q[0].data);
        else n_pass++;
        void'(q.pop_front());
      end else begin
        if (mem_en !== 1'b0) $display("FAIL rnd_idle c=%0d got en=%0b want 0", c, mem_en);
        else n_pass++;
      end
      if (disp_req) rq.push_back('{c + 2, fw ? 8'h00 : ram[disp_addr], fw});
      n_checks++;
      if (rq.size() > 0 && rq[0].due == c) begin
        exp = rq[0].dummy ? last_del : rq[0].data;
        last_del = exp;
        void'(rq.pop_front());
        if ({disp_valid, disp_data} !== {1'b1, exp})
          $display("FAIL rnd_disp c=%0d got valid=%0b data=%0h want 1 %0h", c, disp_valid, disp_data, exp);
        else n_pass++;
      end else begin
        if (disp_valid !== 1'b0) $display("FAIL rnd_novalid c=%0d got %0b want 0", c, disp_valid);
        else n_pass++;
      end
      if (fw)                          blk = 0;
      else if (disp_req && busy_start) blk++;
      else                             blk = 0;
      if (host_valid && exp_ready && host_addr < 12'(DEPTH)) q.push_back('{host_addr, host_data});
      tick();
    end
    n_checks++;
    if (q.size() + rq.size() != 0) $display("FAIL rnd_drain got %0d pending want 0", q.size() + rq.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid_clear();
    clear_start = 1; clear_color = 8'hEE; host_valid = 1; host_addr = 12'h050; host_data = 8'h66;
    tick();
    clear_start = 0; host_addr = 12'h051;
    tick();
    host_valid = 0;
    repeat (10) tick();
    @(negedge clk);
    n_checks++; if (clear_busy !== 1'b1) $display("FAIL mid_busy got %0b want 1", clear_busy); else n_pass++;
    tick();
    rst = 1;
    @(negedge clk);
    n_checks++;
    if ({clear_busy, mem_en, host_ready, disp_valid} !== 4'b0000)
      $display("FAIL mid_rst got busy=%0b en=%0b ready=%0b valid=%0b want 0000", clear_busy, mem_en, host_ready, disp_valid);
    else n_pass++;
    tick();
    rst = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      @(negedge clk);
      n_checks++;
      if ({mem_en, clear_busy, host_ready} !== 3'b001)
        $display("FAIL mid_after c=%0d got en=%0b busy=%0b ready=%0b want 0 0 1", c, mem_en, clear_busy, host_ready);
      else n_pass++;
    end
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read();
    test_collision();
    test_clear();
    test_backpressure();
`ifdef ARB_STARVE_GUARD_EN
    test_guard();
`endif
    test_random();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
